// File: rtl/fpu_op_sequencer_pkg.sv
// rtl/fpu_op_sequencer_pkg.sv - shared types and constants for the FPU op sequencer
package fpu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } fpu_op_e;

    // Default (half precision) operand width; the top re-derives widths from its own parameters.
    localparam int DEF_DATA_W = 16;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] result;
        logic                  uf;
        logic                  of;
        logic                  ix;
    } fpu_res_t;

    // opA value that marks the end of a program in op memory.
    localparam logic [DEF_DATA_W-1:0] TERMINATOR = '1;

endpackage

// File: rtl/fpu_op_sequencer_if.sv
// rtl/fpu_op_sequencer_if.sv - op memory, FPU issue/result and result stream signals
interface fpu_op_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0]     mem_addr;
    logic                  mem_rd;
    logic [2*DATA_W+1:0]   mem_rdata;
    logic                  fpu_valid;
    logic [1:0]            fpu_op;
    logic [DATA_W-1:0]     fpu_opA;
    logic [DATA_W-1:0]     fpu_opB;
    logic [DATA_W-1:0]     fpu_result;
    logic [2:0]            fpu_flags;
    logic                  res_valid;
    logic                  res_ready;
    logic [DATA_W+2:0]     res_data;

    modport master (
        output mem_addr, mem_rd, fpu_valid, fpu_op, fpu_opA, fpu_opB, res_valid, res_data,
        input  mem_rdata, fpu_result, fpu_flags, res_ready
    );

    modport slave (
        input  mem_addr, mem_rd, fpu_valid, fpu_op, fpu_opA, fpu_opB, res_valid, res_data,
        output mem_rdata, fpu_result, fpu_flags, res_ready
    );
endinterface

// File: rtl/fpu_op_sequencer_fifo.sv
// rtl/fpu_op_sequencer_fifo.sv - synchronous result FIFO with occupancy count
module fpu_seq_fifo #(
    parameter int W     = 19,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [W-1:0]           wdata,
    input  logic                   pop,
    output logic [W-1:0]           rdata,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == ($clog2(DEPTH)+1)'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // Head entry is presented directly so it holds steady until popped; zero when empty.
    assign rdata   = empty ? '0 : mem[rptr];

    // Storage array; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointer and count bookkeeping; a simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/fpu_op_sequencer.sv
// rtl/fpu_op_sequencer.sv - op fetch/issue/capture sequencer; FPU_OP_SEQUENCER_STATS_EN adds flag counters
module fpu_op_sequencer
    import fpu_seq_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 8,
    parameter int FPU_LAT    = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    fpu_op_sequencer_if.master   bus,
    output logic                 busy,
    output logic                 done,
    output logic                 wrap_err,
    output logic [ADDR_W:0]      op_count
`ifdef FPU_OP_SEQUENCER_STATS_EN
    ,
    output logic [ADDR_W:0]      uf_count,
    output logic [ADDR_W:0]      of_count,
    output logic [ADDR_W:0]      ix_count
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = CW + 4;
    localparam logic [DATA_W-1:0] TERM_A = '1;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              uf;
        logic              of;
        logic              ix;
    } res_t;

    seq_state_e        state;
    seq_state_e        state_nx;
    logic [ADDR_W-1:0] addr;
    logic              addr_end;
    logic              rd_pend;
    logic              rd_last;
    logic              issue_v;
    fpu_op_e           issue_op;
    logic [DATA_W-1:0] issue_a;
    logic [DATA_W-1:0] issue_b;
    logic [FPU_LAT-1:0] vsr;
    logic [ADDR_W:0]   cnt;
    logic              wrap_q;
    logic [3:0]        in_flight;
    logic [SW-1:0]     occupancy;
    logic              credit_ok;
    logic              mem_rd;
    logic [DATA_W-1:0] rd_a;
    logic              rd_term;
    logic              rd_issue;
    logic              start_ok;
    logic              cap_push;
    res_t              cap_word;
    logic [CW-1:0]     fifo_count;
    logic              fifo_empty;
    logic              fifo_full;
    logic [DATA_W+2:0] fifo_rdata;

    assign rd_a     = bus.mem_rdata[2*DATA_W-1:DATA_W];
    assign rd_term  = rd_pend && (rd_a == TERM_A);
    assign rd_issue = rd_pend && !rd_term;
    assign start_ok = start && (state == IDLE || state == DONE);
    assign cap_push = vsr[FPU_LAT-1];
    assign cap_word = {bus.fpu_result, bus.fpu_flags};

    // Credit: everything read but not yet in the FIFO, plus what the FIFO already holds.
    always_comb begin
        in_flight = 4'(rd_pend) + 4'(issue_v);
        for (int i = 0; i < FPU_LAT; i++) begin
            in_flight = in_flight + 4'(vsr[i]);
        end
        occupancy = SW'(fifo_count) + SW'(in_flight);
        credit_ok = occupancy < SW'(FIFO_DEPTH);
    end

    // Run control state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and read strobe; reads stop as soon as a terminator is seen or the last address was read.
    always_comb begin
        state_nx = state;
        mem_rd   = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start_ok) state_nx = FETCH;
            end
            FETCH: begin
                mem_rd = credit_ok && !addr_end && !rd_term;
                if (rd_pend && (rd_term || rd_last)) state_nx = DRAIN;
            end
            DRAIN: begin
                if (in_flight == '0 && fifo_empty) state_nx = DONE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Fetch address, issue register, FPU latency tracker and run counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr     <= '0;
            addr_end <= 1'b0;
            rd_pend  <= 1'b0;
            rd_last  <= 1'b0;
            issue_v  <= 1'b0;
            issue_op <= OP_ADD;
            issue_a  <= '0;
            issue_b  <= '0;
            vsr      <= '0;
            cnt      <= '0;
            wrap_q   <= 1'b0;
        end else begin
            rd_pend <= mem_rd;
            issue_v <= rd_issue;
            vsr[0]  <= issue_v;
            for (int i = 1; i < FPU_LAT; i++) begin
                vsr[i] <= vsr[i-1];
            end
            if (start_ok) begin
                addr     <= '0;
                addr_end <= 1'b0;
                cnt      <= '0;
                wrap_q   <= 1'b0;
            end
            if (mem_rd) begin
                addr    <= addr + 1'b1;
                rd_last <= (addr == {ADDR_W{1'b1}});
                if (addr == {ADDR_W{1'b1}}) addr_end <= 1'b1;
            end
            if (rd_issue) begin
                issue_op <= fpu_op_e'(bus.mem_rdata[2*DATA_W+1:2*DATA_W]);
                issue_a  <= rd_a;
                issue_b  <= bus.mem_rdata[DATA_W-1:0];
                cnt      <= cnt + 1'b1;
            end
            if (rd_issue && rd_last) wrap_q <= 1'b1;
        end
    end

`ifdef FPU_OP_SEQUENCER_STATS_EN
    // Flag statistics counted as results enter the FIFO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            uf_count <= '0;
            of_count <= '0;
            ix_count <= '0;
        end else if (start_ok) begin
            uf_count <= '0;
            of_count <= '0;
            ix_count <= '0;
        end else if (cap_push) begin
            if (cap_word.uf) uf_count <= uf_count + 1'b1;
            if (cap_word.of) of_count <= of_count + 1'b1;
            if (cap_word.ix) ix_count <= ix_count + 1'b1;
        end
    end
`endif

    fpu_seq_fifo #(
        .W     (DATA_W + 3),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (cap_push),
        .wdata (cap_word),
        .pop   (bus.res_ready),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    // A push into a full FIFO would mean the read credit was miscounted.
    assert property (@(posedge clk) disable iff (!reset) !(cap_push && fifo_full));

    assign bus.mem_addr  = addr;
    assign bus.mem_rd    = mem_rd;
    assign bus.fpu_valid = issue_v;
    assign bus.fpu_op    = issue_op;
    assign bus.fpu_opA   = issue_a;
    assign bus.fpu_opB   = issue_b;
    assign bus.res_valid = !fifo_empty;
    assign bus.res_data  = fifo_rdata;
    assign busy          = (state == FETCH) || (state == DRAIN);
    assign done          = (state == DONE);
    assign wrap_err      = wrap_q;
    assign op_count      = cnt;
endmodule

// File: tb/tb_fpu_op_sequencer.sv
// tb/tb_fpu_op_sequencer.sv - self-checking bench for fpu_op_sequencer
module tb_fpu_op_sequencer;
    import fpu_seq_pkg::*;

    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 4;
    localparam int FPU_LAT    = 2;
    localparam int FIFO_DEPTH = 8;
    localparam int MW         = 2 + 2*DATA_W;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              busy;
    logic              done;
    logic              wrap_err;
    logic [ADDR_W:0]   op_count;
`ifdef FPU_OP_SEQUENCER_STATS_EN
    logic [ADDR_W:0]   uf_count;
    logic [ADDR_W:0]   of_count;
    logic [ADDR_W:0]   ix_count;
`endif

    fpu_op_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    fpu_op_sequencer #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FPU_LAT(FPU_LAT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .wrap_err (wrap_err),
`ifdef FPU_OP_SEQUENCER_STATS_EN
        .uf_count (uf_count),
        .of_count (of_count),
        .ix_count (ix_count),
`endif
        .op_count (op_count)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int errs = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Op memory: synchronous read, data valid the cycle after mem_rd.
    logic [MW-1:0] opmem [1 << ADDR_W];
    logic [MW-1:0] mem_q;
    always @(posedge clk) if (bus.mem_rd) mem_q <= opmem[bus.mem_addr];
    assign bus.mem_rdata = mem_q;

    // Stand-in FPU: fixed two-cycle latency, flags taken from opB[2:0].
    function automatic fpu_res_t fpu_model(fpu_op_e op, logic [15:0] a, logic [15:0] b);
        fpu_res_t r;
        case (op)
            OP_ADD:  r.result = a + b;
            OP_SUB:  r.result = a - b;
            OP_MUL:  r.result = a * b;
            default: r.result = a ^ b;
        endcase
        {r.uf, r.of, r.ix} = b[2:0];
        return r;
    endfunction

    fpu_res_t p1, p2;
    always @(posedge clk) begin
        p1 <= fpu_model(fpu_op_e'(bus.fpu_op), bus.fpu_opA, bus.fpu_opB);
        p2 <= p1;
    end
    assign bus.fpu_result = p2.result;
    assign bus.fpu_flags  = {p2.uf, p2.of, p2.ix};

    logic res_ready = 1'b1;
    assign bus.res_ready = res_ready;

    typedef struct {
        fpu_op_e           op;
        logic [15:0]       a;
        logic [15:0]       b;
        logic [DATA_W+2:0] exp;
    } vec_t;
    vec_t vt [6];

    logic [DATA_W+2:0] exp_q [$];
    int                rd_cnt = 0;
    bit                rv_seen = 0;
    bit                hold_v = 0;
    logic [DATA_W+2:0] hold_d;

    // Scoreboard: results popped in order, held data checked while stalled.
    always @(negedge clk) begin
        if (reset && bus.res_valid && hold_v) chk("res_stable", 32'(bus.res_data), 32'(hold_d));
        if (reset && bus.res_valid && bus.res_ready) begin
            if (exp_q.size() == 0) begin
                nvec++;
                errs++;
                $display("FAIL extra_result: got %0h expected none", bus.res_data);
            end else begin
                chk("result", 32'(bus.res_data), 32'(exp_q.pop_front()));
            end
        end
        hold_v = reset && bus.res_valid && !bus.res_ready;
        hold_d = bus.res_data;
        if (reset && bus.mem_rd) rd_cnt++;
        if (reset && bus.res_valid) rv_seen = 1;
    end

    task automatic fill_junk();
        for (int i = 0; i < (1 << ADDR_W); i++) opmem[i] = {OP_ADD, 16'h7000 + 16'(i), 16'h0000};
    endtask

    task automatic set_op(int i, int k);
        opmem[i] = {vt[k].op, vt[k].a, vt[k].b};
        exp_q.push_back(vt[k].exp);
    endtask

    task automatic set_term(int i);
        opmem[i] = {OP_ADD, TERMINATOR, 16'h0000};
    endtask

    // Called at posedge+1; returns at the following negedge.
    task automatic pulse_start();
        rd_cnt = 0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("busy_after_start", 32'(busy), 1);
        chk("done_fell", 32'(done), 0);
    endtask

    task automatic wait_done(int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_reached", 32'(done), 1);
        chk("queue_drained", 32'(exp_q.size()), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_mem_rd"}, 32'(bus.mem_rd), 0);
        chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 0);
        chk({tag, "_fpu_valid"}, 32'(bus.fpu_valid), 0);
        chk({tag, "_res_valid"}, 32'(bus.res_valid), 0);
        chk({tag, "_res_data"}, 32'(bus.res_data), 0);
        chk({tag, "_op_count"}, 32'(op_count), 0);
        chk({tag, "_wrap_err"}, 32'(wrap_err), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vt[0] = '{OP_ADD, 16'h0010, 16'h0020, {16'h0030, 3'b000}};
        vt[1] = '{OP_SUB, 16'h0100, 16'h0001, {16'h00FF, 3'b001}};
        vt[2] = '{OP_MUL, 16'h0003, 16'h0005, {16'h000F, 3'b101}};
        vt[3] = '{OP_DIV, 16'h00F0, 16'h0F0F, {16'h0FFF, 3'b111}};
        vt[4] = '{OP_ADD, 16'h1234, 16'h0002, {16'h1236, 3'b010}};
        vt[5] = '{OP_SUB, 16'h0000, 16'h0002, {16'hFFFE, 3'b010}};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check_idle_outputs("post_reset");
        @(posedge clk);
        #1;

        // Three ops then terminator at address 3
        fill_junk();
        for (int i = 0; i < 3; i++) set_op(i, i);
        set_term(3);
        pulse_start();
        wait_done(200);
        chk("t1_op_count", 32'(op_count), 3);
        chk("t1_wrap_err", 32'(wrap_err), 0);
        chk("t1_mem_addr", 32'(bus.mem_addr), 4);

        // Result stream stalled: reads must stop at eight outstanding
        fill_junk();
        for (int i = 0; i < 12; i++) set_op(i, i % 6);
        set_term(12);
        res_ready = 1'b0;
        pulse_start();
        repeat (20) @(negedge clk);
        chk("t2_reads_stalled", 32'(rd_cnt), 8);
        chk("t2_res_valid", 32'(bus.res_valid), 1);
        chk("t2_busy", 32'(busy), 1);
        @(posedge clk);
        #1 res_ready = 1'b1;
        wait_done(300);
        chk("t2_op_count", 32'(op_count), 12);
        chk("t2_wrap_err", 32'(wrap_err), 0);

        // No terminator: run ends on address wrap
        for (int i = 0; i < 16; i++) set_op(i, (i * 5) % 6);
        pulse_start();
        wait_done(300);
        chk("t3_op_count", 32'(op_count), 16);
        chk("t3_wrap_err", 32'(wrap_err), 1);
        chk("t3_mem_addr", 32'(bus.mem_addr), 0);

        // Terminator as the first word
        fill_junk();
        set_term(0);
        rv_seen = 0;
        pulse_start();
        wait_done(100);
        chk("t5b_op_count", 32'(op_count), 0);
        chk("t5b_wrap_err", 32'(wrap_err), 0);
        chk("t5b_no_res_valid", 32'(rv_seen), 0);
        chk("t5b_mem_addr", 32'(bus.mem_addr), 1);

        // start pulsed during FETCH is ignored
        fill_junk();
        for (int i = 0; i < 6; i++) set_op(i, i);
        set_term(6);
        pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        wait_done(200);
        chk("t5a_op_count", 32'(op_count), 6);
        chk("t5a_mem_addr", 32'(bus.mem_addr), 7);

        // Asynchronous reset with ops in flight
        fill_junk();
        for (int i = 0; i < 12; i++) set_op(i, i % 6);
        set_term(12);
        pulse_start();
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        exp_q.delete();
        check_idle_outputs("async_reset");
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        fill_junk();
        for (int i = 0; i < 3; i++) set_op(i, i + 3);
        set_term(3);
        pulse_start();
        wait_done(200);
        chk("t4_op_count", 32'(op_count), 3);

`ifdef FPU_OP_SEQUENCER_STATS_EN
        // Flag statistics: two overflow, one inexact
        fill_junk();
        set_op(0, 0);
        set_op(1, 1);
        set_op(2, 4);
        set_op(3, 5);
        set_op(4, 0);
        set_term(5);
        pulse_start();
        wait_done(200);
        chk("t6_uf_count", 32'(uf_count), 0);
        chk("t6_of_count", 32'(of_count), 2);
        chk("t6_ix_count", 32'(ix_count), 1);
        fill_junk();
        set_term(0);
        pulse_start();
        wait_done(100);
        chk("t6_uf_clear", 32'(uf_count), 0);
        chk("t6_of_clear", 32'(of_count), 0);
        chk("t6_ix_clear", 32'(ix_count), 0);
`endif

        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end
endmodule
